// File: rtl/sum4bit_bcd_pkg.sv
// sum4bit_bcd_pkg: shared types and constants for the sum4bit_bcd converter.
// Holds the FSM state encoding, digit adjust constants, the 7-segment
// table used when SUM4BIT_BCD_SEG7_EN is defined, and small helpers.
package sum4bit_bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int         DIGIT_W    = 4;
  localparam logic [3:0] ADJ_THRESH = 4'd5;
  localparam logic [3:0] ADJ_ADD    = 4'd3;

  // Segment patterns gfedcba, active-high; entry n sits at bits [7n+6:7n].
  localparam logic [69:0] SEG7_LUT = {
    7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
    7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  // Decode one BCD digit; non-decimal codes blank the display.
  function automatic logic [6:0] seg7_decode(input logic [3:0] digit);
    logic [6:0] seg;
    if (digit <= 4'd9) begin
      seg = SEG7_LUT[int'(digit) * 7 +: 7];
    end else begin
      seg = 7'h00;
    end
    return seg;
  endfunction

  // 10^n, used to build the overflow threshold at elaboration time.
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) begin
      p = p * 64'd10;
    end
    return p;
  endfunction

endpackage

// File: rtl/sum4bit_bcd_digit_adj.sv
// bcd_digit_adj: one double-dabble correction cell. A digit of 5 or more
// gets +3 so that the following left shift carries into the next digit.
module bcd_digit_adj
  import sum4bit_bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] i_digit,
  output logic [DIGIT_W-1:0] o_digit
);

  // Conditional +3 adjust, wrapping within 4 bits.
  always_comb begin
    o_digit = i_digit;
    if (i_digit >= ADJ_THRESH) begin
      o_digit = i_digit + ADJ_ADD;
    end else begin
      o_digit = i_digit;
    end
  end

endmodule

// File: rtl/sum4bit_bcd.sv
// sum4bit_bcd: iterative binary-to-BCD converter (double dabble), one bit
// per clock, valid/ready on both sides. Sits after the 4-bit adder.
// Optional 7-segment output enabled by defining SUM4BIT_BCD_SEG7_EN.
module sum4bit_bcd
  import sum4bit_bcd_pkg::*;
#(
  parameter int IN_W   = 5,
  parameter int DIGITS = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [IN_W-1:0]           bin,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [DIGIT_W*DIGITS-1:0] bcd,
  output logic                      ovf,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      busy
`ifdef SUM4BIT_BCD_SEG7_EN
  ,
  output logic [7*DIGITS-1:0]       seg
`endif
);

  localparam int                 BCD_W    = DIGIT_W * DIGITS;
  localparam int                 CNT_W    = $clog2(IN_W + 1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(IN_W - 1);
  localparam logic [63:0]        POW10_W  = pow10(DIGITS);

  state_t             r_state;
  state_t             w_next_state;
  logic [IN_W-1:0]    r_shift;
  logic [BCD_W-1:0]   r_work;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ovf_cap;
  logic [BCD_W-1:0]   r_bcd;
  logic               r_ovf;

  logic [BCD_W-1:0]   w_adj;
  logic [BCD_W-1:0]   w_work_nxt;
  logic [IN_W-1:0]    w_shift_nxt;
  logic               w_ovf_in;
  logic               w_last;

  // Per-digit +3 correction applied before each shift.
  for (genvar d = 0; d < DIGITS; d++) begin : g_adj
    bcd_digit_adj u_adj (
      .i_digit (r_work[d*DIGIT_W +: DIGIT_W]),
      .o_digit (w_adj[d*DIGIT_W +: DIGIT_W])
    );
  end

  // Shift {bcd_work, shift} left by one; bits leaving the top digit are dropped.
  always_comb begin
    w_work_nxt  = (w_adj << 1) | BCD_W'(r_shift[IN_W-1]);
    w_shift_nxt = r_shift << 1;
    w_ovf_in    = (64'(bin) >= POW10_W);
    w_last      = (r_cnt == CNT_LAST);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode and handshake/status outputs.
  always_comb begin
    w_next_state = r_state;
    in_ready     = 1'b0;
    busy         = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = ~rst;
        if (in_valid) begin
          w_next_state = CONV;
        end else begin
          w_next_state = IDLE;
        end
      end
      CONV: begin
        busy = 1'b1;
        if (w_last) begin
          w_next_state = DONE;
        end else begin
          w_next_state = CONV;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_next_state = IDLE;
        end else begin
          w_next_state = DONE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Datapath: capture on accept, iterate in CONV, publish result on the last step.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift   <= '0;
      r_work    <= '0;
      r_cnt     <= '0;
      r_ovf_cap <= 1'b0;
      r_bcd     <= '0;
      r_ovf     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_shift   <= bin;
            r_work    <= '0;
            r_cnt     <= '0;
            r_ovf_cap <= w_ovf_in;
          end
        end
        CONV: begin
          r_shift <= w_shift_nxt;
          r_work  <= w_work_nxt;
          r_cnt   <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_bcd <= w_work_nxt;
            r_ovf <= r_ovf_cap;
          end
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

  assign bcd = r_bcd;
  assign ovf = r_ovf;

`ifdef SUM4BIT_BCD_SEG7_EN
  logic [7*DIGITS-1:0] r_seg;
  logic [7*DIGITS-1:0] w_seg_nxt;

  // Segment patterns for the result about to be loaded into bcd.
  always_comb begin
    w_seg_nxt = '0;
    for (int d = 0; d < DIGITS; d++) begin
      w_seg_nxt[d*7 +: 7] = seg7_decode(w_work_nxt[d*DIGIT_W +: DIGIT_W]);
    end
  end

  // Segment register, updated on the same edge as bcd.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg <= '0;
    end else if ((r_state == CONV) && w_last) begin
      r_seg <= w_seg_nxt;
    end else begin
      r_seg <= r_seg;
    end
  end

  assign seg = r_seg;
`endif

endmodule

// File: tb/tb_sum4bit_bcd.sv
// tb_sum4bit_bcd: directed bench for sum4bit_bcd (IN_W=5 and IN_W=7 builds).
module tb_sum4bit_bcd;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] bin_s;
  logic       iv5, iv7;
  logic       out_ready;

  logic       in_ready5, out_valid5, ovf5, busy5;
  logic [7:0] bcd5;
  logic       in_ready7, out_valid7, ovf7, busy7;
  logic [7:0] bcd7;
`ifdef SUM4BIT_BCD_SEG7_EN
  logic [13:0] seg5, seg7;
`endif

  int n_asserts = 0;
  int n_fail    = 0;

  always #5 clk = ~clk;

  sum4bit_bcd #(.IN_W(5), .DIGITS(2)) u_dut (
    .clk(clk), .rst(rst), .bin(bin_s[4:0]), .in_valid(iv5), .in_ready(in_ready5),
    .bcd(bcd5), .ovf(ovf5), .out_valid(out_valid5), .out_ready(out_ready), .busy(busy5)
`ifdef SUM4BIT_BCD_SEG7_EN
    , .seg(seg5)
`endif
  );

  sum4bit_bcd #(.IN_W(7), .DIGITS(2)) u_dut7 (
    .clk(clk), .rst(rst), .bin(bin_s), .in_valid(iv7), .in_ready(in_ready7),
    .bcd(bcd7), .ovf(ovf7), .out_valid(out_valid7), .out_ready(out_ready), .busy(busy7)
`ifdef SUM4BIT_BCD_SEG7_EN
    , .seg(seg7)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Accept v on the selected DUT and wait for out_valid; no output handshake.
  task automatic convert(input bit sel, input logic [6:0] v, input logic [7:0] exp_bcd,
                         input logic exp_ovf, input string tag);
    int lat;
    int exp_lat;
    exp_lat = sel ? 7 : 5;
    @(negedge clk);
    bin_s = v;
    if (sel) iv7 = 1'b1; else iv5 = 1'b1;
    chk({tag, ":in_ready"}, sel ? in_ready7 : in_ready5, 1);
    @(posedge clk);
    @(negedge clk);
    iv5 = 1'b0;
    iv7 = 1'b0;
    chk({tag, ":busy"}, sel ? busy7 : busy5, 1);
    lat = 0;
    while (!(sel ? out_valid7 : out_valid5) && lat < 20) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    chk({tag, ":latency"}, lat, exp_lat);
    chk({tag, ":bcd"}, sel ? bcd7 : bcd5, exp_bcd);
    chk({tag, ":ovf"}, sel ? ovf7 : ovf5, exp_ovf);
  endtask

  // Complete the output handshake and confirm return to IDLE.
  task automatic handshake(input bit sel, input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, ":ov_drop"}, sel ? out_valid7 : out_valid5, 0);
    chk({tag, ":ready_back"}, sel ? in_ready7 : in_ready5, 1);
  endtask

  initial begin
    int lat;
    logic [7:0] held;
    rst = 1'b1; bin_s = 7'd0; iv5 = 1'b0; iv7 = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst:in_ready", in_ready5, 0);
    chk("rst:out_valid", out_valid5, 0);
    chk("rst:busy", busy5, 0);
    chk("rst:bcd", bcd5, 8'h00);
    chk("rst:ovf", ovf5, 0);
    rst = 1'b0;
    #1;
    chk("rel:in_ready", in_ready5, 1);

    convert(1'b0, 7'd0,  8'h00, 1'b0, "b0");  handshake(1'b0, "b0");
    convert(1'b0, 7'd30, 8'h30, 1'b0, "b30"); handshake(1'b0, "b30");
    convert(1'b0, 7'd19, 8'h19, 1'b0, "b19"); handshake(1'b0, "b19");
    convert(1'b0, 7'd9,  8'h09, 1'b0, "b9");  handshake(1'b0, "b9");

    // Backpressure: result held, new input ignored until handshake.
    convert(1'b0, 7'd21, 8'h21, 1'b0, "bp");
    bin_s = 7'd7;
    iv5 = 1'b1;
    held = bcd5;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("bp:hold_valid", out_valid5, 1);
      chk("bp:hold_bcd", bcd5, held);
      chk("bp:no_ready", in_ready5, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp:idle_ready", in_ready5, 1);
    @(posedge clk);
    @(negedge clk);
    iv5 = 1'b0;
    chk("bp:accept7", busy5, 1);
    lat = 0;
    while (!out_valid5 && lat < 20) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    chk("bp7:latency", lat, 5);
    chk("bp7:bcd", bcd5, 8'h07);
    handshake(1'b0, "bp7");

    // Reset on the 3rd CONV cycle aborts cleanly.
    @(negedge clk);
    bin_s = 7'd25;
    iv5 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv5 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rstmid:out_valid", out_valid5, 0);
    chk("rstmid:bcd", bcd5, 8'h00);
    chk("rstmid:busy", busy5, 0);
    chk("rstmid:in_ready", in_ready5, 0);
    rst = 1'b0;
    convert(1'b0, 7'd25, 8'h25, 1'b0, "b25"); handshake(1'b0, "b25");

    // 27 also exercises the optional segment decoder.
    convert(1'b0, 7'd27, 8'h27, 1'b0, "b27");
`ifdef SUM4BIT_BCD_SEG7_EN
    chk("seg27:hi", {25'd0, seg5[13:7]}, 32'h5B);
    chk("seg27:lo", {25'd0, seg5[6:0]}, 32'h07);
`endif
    handshake(1'b0, "b27");

    // Every adder result x0+x1 for 4-bit operands.
    for (int x0 = 0; x0 < 16; x0++) begin
      for (int x1 = 0; x1 < 16; x1++) begin
        int s;
        logic [7:0] e;
        s = x0 + x1;
        e = 8'((s / 10) * 16 + (s % 10));
        convert(1'b0, 7'(s), e, 1'b0, "sweep");
        handshake(1'b0, "sweep");
      end
    end

    // Wider input: values past 99 flag overflow and keep the low two digits.
    convert(1'b1, 7'd100, 8'h00, 1'b1, "w100"); handshake(1'b1, "w100");
    convert(1'b1, 7'd127, 8'h27, 1'b1, "w127"); handshake(1'b1, "w127");
    convert(1'b1, 7'd99,  8'h99, 1'b0, "w99");  handshake(1'b1, "w99");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
